// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_pkg
//  Purpose  : Shared register offsets and field encodings for the GPIO block.
//  Revision : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    // Register byte offsets; only bits [3:2] are decoded by the block.
    localparam logic [3:0] GPIO_MODE    = 4'h0;
    localparam logic [3:0] GPIO_DATA    = 4'h4;
    localparam logic [3:0] GPIO_INTCFG  = 4'h8;
    localparam logic [3:0] GPIO_INTPEND = 4'hC;

    // Per-pin mode field encoding.
    typedef enum logic [1:0] {
        MODE_HIZ     = 2'b00,
        MODE_OUT     = 2'b01,
        MODE_IN      = 2'b10,
        MODE_HIZ_ALT = 2'b11
    } gpio_mode_e;

    // Per-pin interrupt edge selection.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } gpio_edge_e;

    // True when the configured edge type reacts to a rising edge.
    function automatic logic edge_on_rise(input logic [1:0] cfg);
        return (cfg == EDGE_RISE) || (cfg == EDGE_BOTH);
    endfunction

    // True when the configured edge type reacts to a falling edge.
    function automatic logic edge_on_fall(input logic [1:0] cfg);
        return (cfg == EDGE_FALL) || (cfg == EDGE_BOTH);
    endfunction

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_sync_edge
//  Purpose  : Two-flop synchronizer for one asynchronous pad input plus a
//             "previous" flop giving single-cycle rise/fall pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain followed by one history stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise =  r_sync & ~r_prev;
    assign o_fall = ~r_sync &  r_prev;

endmodule : gpio_sync_edge
`default_nettype wire

// File: rtl/gpio_top.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_top
//  Purpose  : Memory-mapped GPIO with per-pin mode, output data, synchronized
//             input sampling and edge-triggered interrupts (pins 0..7).
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_top
    import gpio_pkg::*;
#(
    // Legal range 1..16: every pin needs two mode bits in a 32-bit register.
    parameter int unsigned GPIO_NUM = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic [GPIO_NUM-1:0] gpio_oe_o,
    output logic [GPIO_NUM-1:0] gpio_data_o,
    input  logic [GPIO_NUM-1:0] gpio_data_i,
    output logic                irq_gpio0_o,
    output logic                irq_gpio1_o,
    output logic                irq_gpio2_4_o,
    output logic                irq_gpio5_7_o,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [3:0]          be_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o
);

    // Only the first eight pins can raise interrupts.
    localparam int unsigned c_irq_num = (GPIO_NUM < 8) ? GPIO_NUM : 8;
    localparam int unsigned c_mode_w  = 2 * GPIO_NUM;
    localparam int unsigned c_cfg_w   = 2 * c_irq_num;

    logic [c_mode_w-1:0]  r_mode;
    logic [GPIO_NUM-1:0]  r_data;
    logic [c_cfg_w-1:0]   r_intcfg;
    logic [c_irq_num-1:0] r_pend;

    logic [c_mode_w-1:0]  w_mode_nxt;
    logic [GPIO_NUM-1:0]  w_data_nxt;
    logic [c_cfg_w-1:0]   w_cfg_nxt;
    logic [c_irq_num-1:0] w_pend_set;
    logic [c_irq_num-1:0] w_pend_clr;

    logic [GPIO_NUM-1:0]  w_sync;
    logic [GPIO_NUM-1:0]  w_rise;
    logic [GPIO_NUM-1:0]  w_fall;
    logic [GPIO_NUM-1:0]  w_is_in;
    logic [GPIO_NUM-1:0]  w_data_rd;
    logic [31:0]          w_rdata;
    logic [7:0]           w_pend8;

    logic w_wr;
    logic w_rd;
    logic w_sel_mode;
    logic w_sel_data;
    logic w_sel_cfg;
    logic w_sel_pend;

    // Address bits outside [3:2], unused byte lanes and non-interrupt pins.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, addr_i[31:4], addr_i[1:0], data_i, be_i, w_rise, w_fall};

    assign w_wr       = req_i &  we_i;
    assign w_rd       = req_i & ~we_i;
    assign w_sel_mode = (addr_i[3:2] == GPIO_MODE[3:2]);
    assign w_sel_data = (addr_i[3:2] == GPIO_DATA[3:2]);
    assign w_sel_cfg  = (addr_i[3:2] == GPIO_INTCFG[3:2]);
    assign w_sel_pend = (addr_i[3:2] == GPIO_INTPEND[3:2]);

    // Byte-lane merge for MODE: each bit follows the enable of its byte.
    for (genvar g = 0; g < c_mode_w; g++) begin : g_mode_bit
        assign w_mode_nxt[g] = be_i[g/8] ? data_i[g] : r_mode[g];
    end

    // Per-pin datapath: synchronizer, output enable, DATA read view.
    for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
        gpio_sync_edge u_sync_edge (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_pin  (gpio_data_i[g]),
            .o_sync (w_sync[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );

        assign w_data_nxt[g]  = be_i[g/8] ? data_i[g] : r_data[g];
        assign w_is_in[g]     = (r_mode[2*g +: 2] == MODE_IN);
        assign gpio_oe_o[g]   = (r_mode[2*g +: 2] == MODE_OUT);
        assign w_data_rd[g]   = w_is_in[g] ? w_sync[g] : r_data[g];
    end

    assign gpio_data_o = r_data;

    // Byte-lane merge for INTCFG.
    for (genvar g = 0; g < c_cfg_w; g++) begin : g_cfg_bit
        assign w_cfg_nxt[g] = be_i[g/8] ? data_i[g] : r_intcfg[g];
    end

    // Interrupt sources: edges count only while the pin is an input.
    for (genvar g = 0; g < c_irq_num; g++) begin : g_irq
        assign w_pend_set[g] = w_is_in[g] &
                               ((edge_on_rise(r_intcfg[2*g +: 2]) & w_rise[g]) |
                                (edge_on_fall(r_intcfg[2*g +: 2]) & w_fall[g]));
        assign w_pend_clr[g] = w_wr & w_sel_pend & be_i[0] & data_i[g];
    end

    // Configuration and output-data registers, written by the bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode   <= '0;
            r_data   <= '0;
            r_intcfg <= '0;
        end else if (w_wr) begin
            if (w_sel_mode) r_mode   <= w_mode_nxt;
            if (w_sel_data) r_data   <= w_data_nxt;
            if (w_sel_cfg)  r_intcfg <= w_cfg_nxt;
        end
    end

    // Pending flags: new edges take priority over a same-cycle W1C.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

    // Read multiplexer; unimplemented bits read as zero.
    always_comb begin
        w_rdata = '0;
        case (addr_i[3:2])
            GPIO_MODE[3:2]:    w_rdata[c_mode_w-1:0]  = r_mode;
            GPIO_DATA[3:2]:    w_rdata[GPIO_NUM-1:0]  = w_data_rd;
            GPIO_INTCFG[3:2]:  w_rdata[c_cfg_w-1:0]   = r_intcfg;
            default:           w_rdata[c_irq_num-1:0] = r_pend;
        endcase
    end

    // Registered read data; holds its value when no read is in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o <= '0;
        end else if (w_rd) begin
            data_o <= w_rdata;
        end
    end

    // Zero-extend pending flags so absent pins tie their groups low.
    always_comb begin
        w_pend8                = '0;
        w_pend8[c_irq_num-1:0] = r_pend;
    end

    assign irq_gpio0_o   = w_pend8[0];
    assign irq_gpio1_o   = w_pend8[1];
    assign irq_gpio2_4_o = |w_pend8[4:2];
    assign irq_gpio5_7_o = |w_pend8[7:5];

endmodule : gpio_top
`default_nettype wire

// File: tb/tb_gpio_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_top
//  Purpose  : Self-checking bench for gpio_top (GPIO_NUM = 2): table of bus
//             vectors plus directed input-sync and interrupt sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  gpio_oe;
    logic [1:0]  gpio_dout;
    logic [1:0]  gpio_din;
    logic        irq0, irq1, irq2_4, irq5_7;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_top #(.GPIO_NUM(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .gpio_oe_o     (gpio_oe),
        .gpio_data_o   (gpio_dout),
        .gpio_data_i   (gpio_din),
        .irq_gpio0_o   (irq0),
        .irq_gpio1_o   (irq1),
        .irq_gpio2_4_o (irq2_4),
        .irq_gpio5_7_o (irq5_7),
        .req_i         (req),
        .we_i          (we),
        .be_i          (be),
        .addr_i        (addr),
        .data_i        (wdata),
        .data_o        (rdata)
    );

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_oe;
        logic [1:0]  exp_dout;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts and ends at a falling edge; request is sampled at the rising edge.
    task automatic bus(input bit w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; gpio_din = 2'b00;
        req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;

        //              we  be     addr   wdata          exp_rd  oe     dout
        tbl.push_back('{0, 4'hF, 32'h0, 32'h0,          32'h0, 2'b00, 2'b00});
        tbl.push_back('{0, 4'hF, 32'h4, 32'h0,          32'h0, 2'b00, 2'b00});
        tbl.push_back('{0, 4'hF, 32'h8, 32'h0,          32'h0, 2'b00, 2'b00});
        tbl.push_back('{0, 4'hF, 32'hC, 32'h0,          32'h0, 2'b00, 2'b00});
        tbl.push_back('{1, 4'hF, 32'h0, 32'h1,          32'h0, 2'b01, 2'b00});
        tbl.push_back('{1, 4'hF, 32'h4, 32'h3,          32'h0, 2'b01, 2'b11});
        tbl.push_back('{0, 4'hF, 32'h4, 32'h0,          32'h3, 2'b01, 2'b11});
        tbl.push_back('{0, 4'hF, 32'h0, 32'h0,          32'h1, 2'b01, 2'b11});
        tbl.push_back('{1, 4'h0, 32'h0, 32'hFFFF_FFFF,  32'h0, 2'b01, 2'b11});
        tbl.push_back('{0, 4'hF, 32'h0, 32'h0,          32'h1, 2'b01, 2'b11});
        tbl.push_back('{1, 4'hF, 32'h4, 32'hFFFF_FFFF,  32'h0, 2'b01, 2'b11});
        tbl.push_back('{0, 4'hF, 32'h4, 32'h0,          32'h3, 2'b01, 2'b11});
        tbl.push_back('{1, 4'hF, 32'h0, 32'h4,          32'h0, 2'b10, 2'b11});
        tbl.push_back('{0, 4'hF, 32'h0, 32'h0,          32'h4, 2'b10, 2'b11});
        tbl.push_back('{1, 4'h1, 32'h0, 32'hFF,         32'h0, 2'b00, 2'b11});
        tbl.push_back('{0, 4'hF, 32'h0, 32'h0,          32'hF, 2'b00, 2'b11});
        tbl.push_back('{1, 4'hF, 32'h8, 32'hFFFF_FFFF,  32'h0, 2'b00, 2'b11});
        tbl.push_back('{0, 4'hF, 32'h8, 32'h0,          32'hF, 2'b00, 2'b11});
        tbl.push_back('{1, 4'hF, 32'h8, 32'h0,          32'h0, 2'b00, 2'b11});
        tbl.push_back('{0, 4'hF, 32'h8, 32'h0,          32'h0, 2'b00, 2'b11});
        tbl.push_back('{1, 4'h1, 32'h4, 32'hFFFF_FFFE,  32'h0, 2'b00, 2'b10});
        tbl.push_back('{0, 4'hF, 32'h4, 32'h0,          32'h2, 2'b00, 2'b10});
        tbl.push_back('{1, 4'hE, 32'h4, 32'h0,          32'h0, 2'b00, 2'b10});
        tbl.push_back('{1, 4'hF, 32'h4, 32'h0,          32'h0, 2'b00, 2'b00});
        tbl.push_back('{0, 4'hF, 32'h4, 32'h0,          32'h0, 2'b00, 2'b00});

        // Reset state.
        idle(3);
        check("reset_oe",   {30'd0, gpio_oe},   32'h0);
        check("reset_dout", {30'd0, gpio_dout}, 32'h0);
        check("reset_irq",  {28'd0, irq5_7, irq2_4, irq1, irq0}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Table-driven register access.
        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd);
            if (!tbl[i].we)
                check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
            check($sformatf("vec%0d_oe", i),   {30'd0, gpio_oe},   {30'd0, tbl[i].exp_oe});
            check($sformatf("vec%0d_dout", i), {30'd0, gpio_dout}, {30'd0, tbl[i].exp_dout});
            check($sformatf("vec%0d_irq", i),  {28'd0, irq5_7, irq2_4, irq1, irq0}, 32'h0);
        end

        // Pin 1 as input: synced value visible only after two flops.
        bus(1, 4'hF, 32'h0, 32'h8);
        gpio_din = 2'b10;
        bus(0, 4'hF, 32'h4, 32'h0);
        check("sync_read_e1", rdata, 32'h0);
        bus(0, 4'hF, 32'h4, 32'h0);
        check("sync_read_e2", rdata, 32'h0);
        bus(0, 4'hF, 32'h4, 32'h0);
        check("sync_read_e3", rdata, 32'h2);

        // Pin 1 rising-edge interrupt; an unconfigured falling edge is ignored.
        bus(1, 4'hF, 32'h8, 32'h4);
        gpio_din = 2'b00;
        idle(4);
        bus(0, 4'hF, 32'hC, 32'h0);
        check("fall_ignored_pend", rdata, 32'h0);
        gpio_din = 2'b10;
        idle(1);
        check("rise_irq1_c1", {31'd0, irq1}, 32'h0);
        idle(1);
        check("rise_irq1_c2", {31'd0, irq1}, 32'h0);
        idle(1);
        check("rise_irq1_c3", {31'd0, irq1}, 32'h1);
        bus(0, 4'hF, 32'hC, 32'h0);
        check("rise_pend_read", rdata, 32'h2);
        bus(1, 4'hF, 32'hC, 32'h1);
        check("w1c_other_bit_irq1", {31'd0, irq1}, 32'h1);
        bus(1, 4'hF, 32'hC, 32'h2);
        check("w1c_irq1", {31'd0, irq1}, 32'h0);
        bus(0, 4'hF, 32'hC, 32'h0);
        check("w1c_pend_read", rdata, 32'h0);

        // Pin 0 both edges: falling edge lands on the same cycle as its W1C.
        bus(1, 4'hF, 32'h0, 32'hA);
        bus(1, 4'hF, 32'h8, 32'h7);
        gpio_din = 2'b11;
        idle(3);
        check("both_rise_irq0", {31'd0, irq0}, 32'h1);
        gpio_din = 2'b10;
        idle(2);
        bus(1, 4'h1, 32'hC, 32'h1);
        check("set_wins_irq0", {31'd0, irq0}, 32'h1);
        bus(1, 4'h1, 32'hC, 32'h1);
        check("clear_irq0", {31'd0, irq0}, 32'h0);
        check("irq1_quiet", {31'd0, irq1}, 32'h0);

        // Edges on a pin that is not in input mode never pend.
        bus(1, 4'hF, 32'h0, 32'h9);
        gpio_din = 2'b11;
        idle(4);
        gpio_din = 2'b10;
        idle(4);
        check("non_input_no_irq0", {31'd0, irq0}, 32'h0);
        check("groups_tied_low", {30'd0, irq5_7, irq2_4}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gpio_top
`default_nettype wire
